alu_seq: RTL and testbench

Parametrised, multicycle ALU for the multicycle CPU datapath.
- Extends the basic 8-op combinational ALU with:
  - configurable data width
  - set-less-than and shift operations
  - a signed-overflow flag
  - an iterative multiply/divide unit behind a start/done handshake
- Sits between the A/B operand registers and the ALUOut register.
- The control FSM issues `start` and waits for `done` before latching the result.

---
 rtl/alu_seq_if.sv | 16 +
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/done handshake bundle between the control FSM (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  modport master (output start, op, a, b, input busy, done, result, zero, ovf);
  modport slave  (input start, op, a, b, output busy, done, result, zero, ovf);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multicycle ALU with start/done handshake; ALU_SEQ_MULDIV_EN adds iterative MUL/DIVU/REMU.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE, DONE, MUL, DIV} state_t;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_r, sum, dif;
  logic             zero_q, zero_d, ovf_q, ovf_d, alu_ovf;
  logic [SHW-1:0]   sh;
`ifdef ALU_SEQ_MULDIV_EN
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, quo_q, quo_d;
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH:0]   rem_sh, diff;
`endif
  assign bus.busy   = state_q != IDLE;
  assign bus.done   = state_q == DONE;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
  always_comb begin
    sum     = bus.a + bus.b;
    dif     = bus.a - bus.b;
    sh      = bus.b[SHW-1:0];
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      4'b0010: begin
        alu_r   = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0011: begin
        alu_r   = dif;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0100: alu_r = bus.a & bus.b;
      4'b0101: alu_r = bus.a | bus.b;
      4'b0110: alu_r = bus.a ^ bus.b;
      4'b0111: alu_r = ~(bus.a | bus.b);
      4'b1000: alu_r = WIDTH'($signed(bus.a) < $signed(bus.b));
      4'b1001: alu_r = WIDTH'(bus.a < bus.b);
      4'b1010: alu_r = bus.a << sh;
      4'b1011: alu_r = bus.a >> sh;
      4'b1100: alu_r = $signed(bus.a) >>> sh;
      default: alu_r = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef ALU_SEQ_MULDIV_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    quo_d     = quo_q;
    rem_sel_d = rem_sel_q;
    rem_sh    = {acc_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, mcand_q};
`endif
    case (state_q)
      IDLE: if (bus.start) begin
`ifdef ALU_SEQ_MULDIV_EN
        if (bus.op == 4'b1101) begin
          state_d = MUL;
          acc_d   = '0;
          mcand_d = bus.a;
          quo_d   = bus.b;
          cnt_d   = (SHW+1)'(WIDTH);
        end else if (bus.op[3:1] == 3'b111) begin
          state_d   = DIV;
          acc_d     = '0;
          mcand_d   = bus.b;
          quo_d     = bus.a;
          cnt_d     = (SHW+1)'(WIDTH);
          rem_sel_d = bus.op[0];
        end else
`endif
        begin
          state_d  = DONE;
          result_d = alu_r;
          zero_d   = alu_r == '0;
          ovf_d    = alu_ovf;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      MUL: begin
        acc_d   = acc_q + (quo_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        quo_d   = quo_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d  = DONE;
          result_d = acc_d;
          zero_d   = acc_d == '0;
          ovf_d    = 1'b0;
        end
      end
      DIV: begin
        // a negative trial difference restores the shifted remainder and shifts in a 0 quotient bit
        acc_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d  = DONE;
          result_d = rem_sel_q ? acc_d : quo_d;
          zero_d   = result_d == '0;
          ovf_d    = 1'b0;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      quo_q     <= '0;
      rem_sel_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      quo_q     <= quo_d;
      rem_sel_q <= rem_sel_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32); honours ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0011, AND_ = 4'b0100, OR_ = 4'b0101;
  localparam logic [3:0] XOR_ = 4'b0110, NOR_ = 4'b0111, SLT = 4'b1000, SLTU = 4'b1001;
  localparam logic [3:0] SLL = 4'b1010, SRL = 4'b1011, SRA = 4'b1100;
  localparam logic [3:0] MUL = 4'b1101, DIVU = 4'b1110, REMU = 4'b1111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 200) begin @(negedge clk); g++; end
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = '1; bus.b = '1;
    lat = 1;
    while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", bus.result); end
    tests++; if (bus.zero !== 1'b1) begin fails++; $display("FAIL reset_zero got %b want 1", bus.zero); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_add_sub;
    int lat;
    issue(ADD, 32'h7FFF_FFFF, 32'h1, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency got %0d want 1", lat); end
    tests++; if (bus.result !== 32'h8000_0000) begin fails++; $display("FAIL add_result got %h want 80000000", bus.result); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL add_ovf got %b want 1", bus.ovf); end
    tests++; if (bus.zero !== 1'b0) begin fails++; $display("FAIL add_zero got %b want 0", bus.zero); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL add_busy_in_done got %b want 1", bus.busy); end
    @(posedge clk); #1;
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL add_idle_after got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    issue(SUB, 32'd5, 32'd5, lat);
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL sub_result got %h want 0", bus.result); end
    tests++; if (bus.zero !== 1'b1) begin fails++; $display("FAIL sub_zero got %b want 1", bus.zero); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL sub_ovf got %b want 0", bus.ovf); end
    issue(SUB, 32'h8000_0000, 32'h1, lat);
    tests++; if (bus.result !== 32'h7FFF_FFFF) begin fails++; $display("FAIL subovf_result got %h want 7fffffff", bus.result); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL subovf_ovf got %b want 1", bus.ovf); end
    issue(ADD, 32'hFFFF_FFFF, 32'h1, lat);
    tests++; if (bus.result !== 32'h0 || bus.ovf !== 1'b0 || bus.zero !== 1'b1) begin fails++; $display("FAIL add_wrap got %h ovf=%b zero=%b want 0 0 1", bus.result, bus.ovf, bus.zero); end
  endtask

  task automatic test_logic;
    int lat;
    issue(AND_, 32'hF0F0_1234, 32'hFF00_00FF, lat);
    tests++; if (bus.result !== 32'hF000_0034) begin fails++; $display("FAIL and got %h want f0000034", bus.result); end
    issue(OR_, 32'hF0F0_1234, 32'hFF00_00FF, lat);
    tests++; if (bus.result !== 32'hFFF0_12FF) begin fails++; $display("FAIL or got %h want fff012ff", bus.result); end
    issue(XOR_, 32'hF0F0_1234, 32'hFF00_00FF, lat);
    tests++; if (bus.result !== 32'h0FF0_12CB) begin fails++; $display("FAIL xor got %h want 0ff012cb", bus.result); end
    issue(NOR_, 32'hF0F0_1234, 32'hFF00_00FF, lat);
    tests++; if (bus.result !== 32'h000F_ED00) begin fails++; $display("FAIL nor got %h want 000fed00", bus.result); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL nor_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_compare_shift;
    int lat;
    issue(SLT, 32'hFFFF_FFFF, 32'h1, lat);
    tests++; if (bus.result !== 32'h1) begin fails++; $display("FAIL slt got %h want 1", bus.result); end
    issue(SLTU, 32'hFFFF_FFFF, 32'h1, lat);
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL sltu got %h want 0", bus.result); end
    issue(SRA, 32'h8000_0000, 32'h24, lat);
    tests++; if (bus.result !== 32'hF800_0000) begin fails++; $display("FAIL sra got %h want f8000000", bus.result); end
    issue(SRL, 32'h8000_0000, 32'h24, lat);
    tests++; if (bus.result !== 32'h0800_0000) begin fails++; $display("FAIL srl got %h want 08000000", bus.result); end
    issue(SLL, 32'h0000_0003, 32'h1F, lat);
    tests++; if (bus.result !== 32'h8000_0000) begin fails++; $display("FAIL sll got %h want 80000000", bus.result); end
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic test_mul;
    int lat;
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 200) begin @(negedge clk); g++; end
    bus.start = 1'b1; bus.op = MUL; bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 4) begin bus.start = 1'b1; bus.op = ADD; bus.a = 32'd1; bus.b = 32'd1; end
      @(posedge clk); #1; lat++;
      if (lat == 5) begin
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mul_busy_ignore got %b want 1", bus.busy); end
      end
    end
    tests++; if (lat !== 33) begin fails++; $display("FAIL mul_latency got %0d want 33", lat); end
    tests++; if (bus.result !== 32'hFFFF_FFFD) begin fails++; $display("FAIL mul_result got %h want fffffffd", bus.result); end
    tests++; if (bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin fails++; $display("FAIL mul_flags got ovf=%b zero=%b want 0 0", bus.ovf, bus.zero); end
    bus.start = 1'b1; bus.op = ADD; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk); #1;
    tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL start_in_done got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    tests++; if (bus.result !== 32'hFFFF_FFFD) begin fails++; $display("FAIL start_in_done_hold got %h want fffffffd", bus.result); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++; if (bus.done !== 1'b1 || bus.result !== 32'd5) begin fails++; $display("FAIL reaccept got done=%b result=%h want 1 5", bus.done, bus.result); end
    issue(MUL, 32'h0001_0000, 32'h0001_0000, lat);
    tests++; if (bus.result !== 32'h0 || bus.zero !== 1'b1 || lat !== 33) begin fails++; $display("FAIL mul_wrap got %h zero=%b lat=%0d want 0 1 33", bus.result, bus.zero, lat); end
  endtask

  task automatic test_div;
    int lat;
    issue(DIVU, 32'd100, 32'd7, lat);
    tests++; if (bus.result !== 32'd14 || lat !== 33) begin fails++; $display("FAIL divu got %h lat=%0d want e 33", bus.result, lat); end
    issue(REMU, 32'd100, 32'd7, lat);
    tests++; if (bus.result !== 32'd2) begin fails++; $display("FAIL remu got %h want 2", bus.result); end
    issue(REMU, 32'hFFFF_FFFF, 32'h10, lat);
    tests++; if (bus.result !== 32'hF) begin fails++; $display("FAIL remu_big got %h want f", bus.result); end
    issue(DIVU, 32'h1234_5678, 32'h0, lat);
    tests++; if (bus.result !== 32'hFFFF_FFFF || lat !== 33) begin fails++; $display("FAIL divu_zero got %h lat=%0d want ffffffff 33", bus.result, lat); end
    issue(REMU, 32'd9, 32'h0, lat);
    tests++; if (bus.result !== 32'd9) begin fails++; $display("FAIL remu_zero got %h want 9", bus.result); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 200) begin @(negedge clk); g++; end
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    tests++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin fails++; $display("FAIL rstmid_result got %h zero=%b want 0 1", bus.result, bus.zero); end
    repeat (40) begin
      if (bus.done) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_done got %0d pulses want 0", seen); end
  endtask
`else
  task automatic test_no_muldiv;
    int lat;
    issue(ADD, 32'd1, 32'd1, lat);
    issue(MUL, 32'd3, 32'd4, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL nomul_latency got %0d want 1", lat); end
    tests++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin fails++; $display("FAIL nomul_result got %h zero=%b want 0 1", bus.result, bus.zero); end
    issue(DIVU, 32'd100, 32'd7, lat);
    tests++; if (lat !== 1 || bus.result !== 32'h0) begin fails++; $display("FAIL nodivu got %h lat=%0d want 0 1", bus.result, lat); end
    issue(REMU, 32'd100, 32'd7, lat);
    tests++; if (lat !== 1 || bus.result !== 32'h0) begin fails++; $display("FAIL noremu got %h lat=%0d want 0 1", bus.result, lat); end
  endtask
`endif

  initial begin
    test_reset;
    test_add_sub;
    test_logic;
    test_compare_shift;
`ifdef ALU_SEQ_MULDIV_EN
    test_mul;
    test_div;
    test_reset_mid;
`else
    test_no_muldiv;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
